// File: rtl/sync_frame_pkg.sv
// Shared types and constants for the sync-framed serial link.
// Holds the FSM state enum and the default sync pattern shared with the detector.
package sync_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_GAP
    } state_e;

    localparam int                    SYNC_W_DEF = 5;
    localparam logic [SYNC_W_DEF-1:0] SYNC_DEF   = 5'b10110;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/sync_frame_tx_piso_shift.sv
// Parallel-in serial-out shift register: load a word, shift left, tap the MSB.
// Ports: clk, rst (async high), load, shift, din[W-1:0], msb (current top bit).
module piso_shift #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);

    logic [W-1:0] sr_q;
    logic [W-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = din;
        end else if (shift) begin
            sr_d = sr_q << 1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign msb = sr_q[W-1];

endmodule

// File: rtl/sync_frame_tx.sv
// Framed serial transmitter: sync pattern, payload MSB-first, then idle gap.
// Ports: clk, rst (async high), in_valid/in_data/in_ready handshake,
//        o serial line, o_valid, sync_active, busy, frame_done pulse.
module sync_frame_tx
    import sync_frame_pkg::*;
#(
    parameter int                DATA_W = 8,
    parameter int                SYNC_W = SYNC_W_DEF,
    parameter logic [SYNC_W-1:0] SYNC   = SYNC_DEF,
    parameter int                GAP    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              o,
    output logic              o_valid,
    output logic              sync_active,
    output logic              busy,
    output logic              frame_done
);

    localparam int CNT_MAX = max3(SYNC_W, DATA_W, GAP);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Counter holds the number of cycles left in the current state after this one.
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP > 0) ? GAP - 1 : 0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             o_q, o_d;
    logic             o_valid_q, o_valid_d;
    logic             sync_active_q, sync_active_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;
    logic             in_ready_q, in_ready_d;

    logic             accept;
    logic             data_shift;
    logic             sync_shift;
    logic             data_msb;
    logic             sync_msb;

    // in_ready_q is only set while idle, so it alone qualifies acceptance.
    assign accept = in_valid && in_ready_q;

    // The first sync bit goes out straight from the parameter on the
    // acceptance edge, so the sync register is loaded pre-shifted.
    piso_shift #(
        .W(SYNC_W)
    ) u_sync_sr (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .shift(sync_shift),
        .din  (SYNC << 1),
        .msb  (sync_msb)
    );

    piso_shift #(
        .W(DATA_W)
    ) u_data_sr (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .shift(data_shift),
        .din  (in_data),
        .msb  (data_msb)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        o_d           = 1'b0;
        o_valid_d     = 1'b0;
        sync_active_d = 1'b0;
        frame_done_d  = 1'b0;
        in_ready_d    = 1'b0;
        data_shift    = 1'b0;
        sync_shift    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                in_ready_d = 1'b1;
                if (accept) begin
                    state_d       = ST_SYNC;
                    cnt_d         = SYNC_LAST;
                    o_d           = SYNC[SYNC_W-1];
                    o_valid_d     = 1'b1;
                    sync_active_d = 1'b1;
                    in_ready_d    = 1'b0;
                end
            end
            ST_SYNC: begin
                o_valid_d = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d         = cnt_q - CNT_W'(1);
                    o_d           = sync_msb;
                    sync_shift    = 1'b1;
                    sync_active_d = 1'b1;
                end else begin
                    state_d    = ST_DATA;
                    cnt_d      = DATA_LAST;
                    o_d        = data_msb;
                    data_shift = 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d      = cnt_q - CNT_W'(1);
                    o_d        = data_msb;
                    data_shift = 1'b1;
                    o_valid_d  = 1'b1;
                end else begin
                    frame_done_d = 1'b1;
                    if (GAP > 0) begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_LAST;
                    end else begin
                        state_d    = ST_IDLE;
                        cnt_d      = '0;
                        in_ready_d = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d    = ST_IDLE;
                    cnt_d      = '0;
                    in_ready_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            o_q           <= 1'b0;
            o_valid_q     <= 1'b0;
            sync_active_q <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            in_ready_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            o_q           <= o_d;
            o_valid_q     <= o_valid_d;
            sync_active_q <= sync_active_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            in_ready_q    <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign o           = o_q;
    assign o_valid     = o_valid_q;
    assign sync_active = sync_active_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_sync_frame_tx.sv
// Directed self-checking bench for sync_frame_tx (default build and a
// DATA_W=4, GAP=0 build sharing one clock).
module tb_sync_frame_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready, o, o_valid, sync_active, busy, frame_done;

    logic       v4;
    logic [3:0] d4;
    logic       r4, o4, ov4, sa4, b4, fd4;

    int checks = 0;
    int errors = 0;
    int fl, fc;

    always #5 clk = ~clk;

    sync_frame_tx dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .o          (o),
        .o_valid    (o_valid),
        .sync_active(sync_active),
        .busy       (busy),
        .frame_done (frame_done)
    );

    sync_frame_tx #(
        .DATA_W(4),
        .GAP   (0)
    ) dut4 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (v4),
        .in_data    (d4),
        .in_ready   (r4),
        .o          (o4),
        .o_valid    (ov4),
        .sync_active(sa4),
        .busy       (b4),
        .frame_done (fd4)
    );

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic chki(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Entered in cycle 1 of a default-build frame; returns in cycle 16.
    task automatic check_frame(input logic [7:0] d, input logic [7:0] nxt,
                               input bit hold, input bit stall,
                               output int flags, output int fcyc);
        logic [12:0] exp_bits;
        logic [3:0]  h;
        exp_bits = {5'b10110, d};
        h        = 4'b0000;
        flags    = 0;
        fcyc     = 0;
        in_data  = nxt;
        in_valid = hold;
        for (int k = 1; k <= 13; k++) begin
            if (stall && k == 7) begin
                in_valid = 1'b1;
                in_data  = 8'h3C;
            end
            if (stall && k == 8) begin
                in_valid = 1'b0;
                in_data  = nxt;
            end
            chk1($sformatf("o %h c%0d", d, k), o, exp_bits[4'(13 - k)]);
            chk1($sformatf("o_valid %h c%0d", d, k), o_valid, 1'b1);
            chk1($sformatf("sync_active %h c%0d", d, k), sync_active, (k <= 5));
            chk1($sformatf("frame_done %h c%0d", d, k), frame_done, 1'b0);
            chk1($sformatf("in_ready %h c%0d", d, k), in_ready, 1'b0);
            chk1($sformatf("busy %h c%0d", d, k), busy, 1'b1);
            if ({h, o} == 5'b10110) begin
                flags++;
                fcyc = k;
            end
            h = {h[2:0], o};
            tick;
        end
        chk1("frame_done c14", frame_done, 1'b1);
        chk1("gap o c14", o, 1'b0);
        chk1("gap o_valid c14", o_valid, 1'b0);
        chk1("in_ready c14", in_ready, 1'b0);
        chk1("busy c14", busy, 1'b1);
        tick;
        chk1("frame_done c15", frame_done, 1'b0);
        chk1("gap o c15", o, 1'b0);
        chk1("gap o_valid c15", o_valid, 1'b0);
        chk1("in_ready c15", in_ready, 1'b0);
        tick;
        chk1("in_ready c16", in_ready, 1'b1);
        chk1("busy c16", busy, 1'b0);
        chk1("frame_done c16", frame_done, 1'b0);
    endtask

    initial begin
        logic [8:0] bits4;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        v4       = 1'b0;
        d4       = 4'h0;
        repeat (2) tick;
        chk1("rst in_ready", in_ready, 1'b0);
        chk1("rst o", o, 1'b0);
        chk1("rst o_valid", o_valid, 1'b0);
        chk1("rst sync_active", sync_active, 1'b0);
        chk1("rst busy", busy, 1'b0);
        chk1("rst frame_done", frame_done, 1'b0);
        chk1("rst in_ready4", r4, 1'b0);
        rst = 1'b0;
        tick;
        chk1("post-rst in_ready", in_ready, 1'b1);
        chk1("post-rst o", o, 1'b0);
        chk1("post-rst in_ready4", r4, 1'b1);

        // Single frame A5; in_data changes after capture.
        in_data  = 8'hA5;
        in_valid = 1'b1;
        tick;
        check_frame(8'hA5, 8'h00, 1'b0, 1'b0, fl, fc);

        // Back-to-back FF then 00 with in_valid held.
        in_data  = 8'hFF;
        in_valid = 1'b1;
        tick;
        check_frame(8'hFF, 8'h00, 1'b1, 1'b0, fl, fc);
        tick;
        check_frame(8'h00, 8'h00, 1'b0, 1'b0, fl, fc);
        chki("detector flags", fl, 1);
        chki("detector cycle", fc, 5);

        // Stall: in_valid pulse with 3C during cycle 7 is ignored.
        in_data  = 8'hC3;
        in_valid = 1'b1;
        tick;
        check_frame(8'hC3, 8'hC3, 1'b0, 1'b1, fl, fc);
        in_valid = 1'b0;
        tick;
        chk1("stall no 2nd o_valid", o_valid, 1'b0);
        chk1("stall no 2nd busy", busy, 1'b0);
        chk1("stall in_ready", in_ready, 1'b1);

        // Abort in cycle 8 of an A5 frame.
        in_data  = 8'hA5;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (7) tick;
        chk1("abort pre o c8", o, 1'b1);
        chk1("abort pre busy", busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk1("abort o", o, 1'b0);
        chk1("abort o_valid", o_valid, 1'b0);
        chk1("abort busy", busy, 1'b0);
        chk1("abort in_ready", in_ready, 1'b0);
        chk1("abort frame_done", frame_done, 1'b0);
        repeat (2) begin
            tick;
            chk1("abort hold frame_done", frame_done, 1'b0);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            chk1($sformatf("post-abort frame_done %0d", i), frame_done, 1'b0);
            chk1($sformatf("post-abort o_valid %0d", i), o_valid, 1'b0);
        end
        chk1("post-abort in_ready", in_ready, 1'b1);
        in_data  = 8'h81;
        in_valid = 1'b1;
        tick;
        check_frame(8'h81, 8'h00, 1'b0, 1'b0, fl, fc);

        // GAP=0, DATA_W=4 build with payload 6.
        bits4 = 9'b101100110;
        d4    = 4'h6;
        v4    = 1'b1;
        tick;
        v4 = 1'b0;
        d4 = 4'h0;
        for (int k = 1; k <= 9; k++) begin
            chk1($sformatf("g0 o c%0d", k), o4, bits4[4'(9 - k)]);
            chk1($sformatf("g0 o_valid c%0d", k), ov4, 1'b1);
            chk1($sformatf("g0 frame_done c%0d", k), fd4, 1'b0);
            chk1($sformatf("g0 in_ready c%0d", k), r4, 1'b0);
            tick;
        end
        chk1("g0 frame_done c10", fd4, 1'b1);
        chk1("g0 in_ready c10", r4, 1'b1);
        chk1("g0 o_valid c10", ov4, 1'b0);
        tick;
        chk1("g0 frame_done c11", fd4, 1'b0);
        chk1("g0 busy c11", b4, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_frame_tx.md
# sync_frame_tx

- Serializes parallel payload words into a framed serial bit stream: a fixed sync pattern (default 10110), then the payload MSB-first, then an idle gap.
- Transmit end of the link whose receive side is the team's 10110 sequence detector. That detector locks on the sync pattern.
- Registered (Moore) outputs; valid/ready handshake on the parallel side.

## Interface
Parameters:
- DATA_W, 8, payload width in bits (≥1)
- SYNC_W, 5, sync pattern width (≥1)
- SYNC, 5'b10110, sync pattern, sent MSB first
- GAP, 2, idle cycles after each frame (≥0)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  payload offered
- in_data  in  DATA_W  payload word
- in_ready  out  1  block can accept a payload this cycle
- o  out  1  serial bit line
- o_valid  out  1  o carries a sync or payload bit
- sync_active  out  1  o carries a sync bit
- busy  out  1  state ≠ IDLE
- frame_done  out  1  one-cycle pulse after the last payload bit

## Operation
- States: IDLE, SYNC, DATA, GAP.
- IDLE:
  - in_ready=1, o=0, o_valid=0.
  - A transfer happens on a rising edge with in_valid&&in_ready. in_data is captured into the shift register and the state goes to SYNC.
- SYNC:
  - SYNC_W cycles with o=SYNC[SYNC_W-1-k] for k=0..SYNC_W-1.
  - o_valid=1, sync_active=1.
  - Then DATA.
- DATA:
  - DATA_W cycles with o=captured[DATA_W-1-k], MSB first.
  - o_valid=1, sync_active=0.
  - Then GAP, or IDLE if GAP=0.
- GAP: GAP cycles with o=0, o_valid=0. Then IDLE.
- frame_done=1 for exactly the first cycle after the last DATA cycle. That cycle is the first GAP cycle, or an IDLE cycle when GAP=0.
- in_ready=0 in every state except IDLE. in_valid in those states is ignored; no payload is lost or queued.
- Changes to in_data after capture have no effect on the frame in flight.
- One down-counter is shared across SYNC/DATA/GAP and reloaded on each state entry. Width is $clog2(max(SYNC_W,DATA_W,GAP)+1).
- Payloads that happen to contain the sync pattern are not escaped; framing integrity is the system's concern.

## Timing
- Reset (async, immediate): state=IDLE, o=0, o_valid=0, sync_active=0, busy=0, frame_done=0, shift register=0, counter=0.
  - in_ready=0 while rst is asserted, and 1 from the first cycle after deassertion.
- Label the acceptance edge as end of cycle 0:
  - cycles 1..SYNC_W: sync bits
  - cycles SYNC_W+1..SYNC_W+DATA_W: payload bits
  - cycle F=SYNC_W+DATA_W+1: frame_done=1
  - in_ready=1 again at cycle F+GAP
- Frame period with in_valid held high is SYNC_W+DATA_W+GAP+1 cycles, including one IDLE acceptance cycle. Default: 16.
- Reset mid-frame aborts the frame. Outputs go to their reset values at once, no frame_done is emitted, and the payload is discarded.
- Simultaneous in_valid and frame completion is not possible: acceptance occurs only in IDLE.

## Structure
- Shared package (e.g. sync_frame_pkg):
  - state enum {IDLE,SYNC,DATA,GAP}
  - default SYNC constant 5'b10110 and SYNC_W
  - the same constant also parameterizes the detector side
- Natural sub-module: piso_shift, a parameterized load/shift-left parallel-in serial-out register with MSB tap. The FSM and counter stay in sync_frame_tx.

## Test plan
- Reset: assert rst mid-cycle → all outputs 0 immediately. Deassert → in_ready=1 next cycle, o=0.
- Single frame in_data=8'hA5, defaults:
  - o over cycles 1..13 = 1,0,1,1,0,1,0,1,0,0,1,0,1
  - o_valid=1 for cycles 1..13; sync_active=1 for cycles 1..5
  - frame_done=1 only at cycle 14; in_ready=1 at cycle 16
- Back-to-back: in_valid held with 8'hFF then 8'h00 → second sync starts at cycle 17. Gap cycles 14–15 show o=0, o_valid=0.
- Busy stall: pulse in_valid with 8'h3C during cycle 7 → ignored; no second frame, in_ready stays 0 until cycle 16.
- Abort: rst asserted in cycle 8 of an 8'hA5 frame → o, o_valid, busy drop to 0 at once; no frame_done. A later 8'h81 frame is transmitted intact.
- GAP=0, DATA_W=4 build with in_data=4'h6:
  - o = 1,0,1,1,0,0,1,1,0
  - frame_done and in_ready both 1 at cycle 10
- Loopback into the 10110 detector with payload 8'h00 → detector flags exactly once, on cycle 5.
